// File: rtl/decode_stage_fwd.sv
// decode_stage_fwd: Y86-64 decode stage with register file,
// fixed-priority operand forwarding and the D/E pipeline register.
module decode_stage_fwd #(
  parameter int          DATA_W   = 64,
  parameter int          NREG     = 15,
  parameter logic [63:0] RSP_INIT = 64'h400,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [2:0]        D_stat_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_ifun_i,
  input  logic [3:0]        D_rA_i,
  input  logic [3:0]        D_rB_i,
  input  logic [DATA_W-1:0] D_valC_i,
  input  logic [DATA_W-1:0] D_valP_i,
  input  logic [3:0]        e_dstE_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [3:0]        M_dstM_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [3:0]        M_dstE_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [3:0]        W_dstM_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [3:0]        W_dstE_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic              E_stall_i,
  input  logic              E_bubble_i,
  output logic              d_load_use_o,
  output logic [2:0]        E_stat_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [DATA_W-1:0] E_valC_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [DATA_W-1:0] E_valB_o,
  output logic [3:0]        E_dstE_o,
  output logic [3:0]        E_dstM_o,
  output logic [3:0]        E_srcA_o,
  output logic [3:0]        E_srcB_o
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [2:0] S_AOK    = 3'd1;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valC;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
  } id_ex_t;

  function automatic id_ex_t de_nop();
    id_ex_t r;
    r.stat  = S_AOK;
    r.icode = I_NOP;
    r.ifun  = 4'h0;
    r.valC  = '0;
    r.valA  = '0;
    r.valB  = '0;
    r.dstE  = R_NONE;
    r.dstM  = R_NONE;
    r.srcA  = R_NONE;
    r.srcB  = R_NONE;
    return r;
  endfunction

  logic [DATA_W-1:0] rf_q [NREG];
  logic [3:0]        d_srcA;
  logic [3:0]        d_srcB;
  logic [3:0]        d_dstE;
  logic [3:0]        d_dstM;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;
  id_ex_t            de_q;
  id_ex_t            de_d;

  always_comb begin
    d_srcA = R_NONE;
    d_srcB = R_NONE;
    d_dstE = R_NONE;
    d_dstM = R_NONE;
    unique case (D_icode_i)
      I_RRMOVQ: begin
        d_srcA = D_rA_i;
        d_dstE = D_rB_i;
      end
      I_IRMOVQ: d_dstE = D_rB_i;
      I_RMMOVQ: begin
        d_srcA = D_rA_i;
        d_srcB = D_rB_i;
      end
      I_MRMOVQ: begin
        d_srcB = D_rB_i;
        d_dstM = D_rA_i;
      end
      I_OPQ: begin
        d_srcA = D_rA_i;
        d_srcB = D_rB_i;
        d_dstE = D_rB_i;
      end
      I_CALL: begin
        d_srcB = R_RSP;
        d_dstE = R_RSP;
      end
      I_RET: begin
        d_srcA = R_RSP;
        d_srcB = R_RSP;
        d_dstE = R_RSP;
      end
      I_PUSHQ: begin
        d_srcA = D_rA_i;
        d_srcB = R_RSP;
        d_dstE = R_RSP;
      end
      I_POPQ: begin
        d_srcA = R_RSP;
        d_srcB = R_RSP;
        d_dstE = R_RSP;
        d_dstM = D_rA_i;
      end
      default: ;
    endcase
  end

  // ids at or above NREG match no entry and read as zero
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (d_srcA == 4'(i)) rf_a = rf_q[i];
      if (d_srcB == 4'(i)) rf_b = rf_q[i];
    end
  end

  always_comb begin
    if (D_icode_i == I_CALL || D_icode_i == I_JXX)
      d_valA = D_valP_i;
    else if (d_srcA == R_NONE)
      d_valA = '0;
    else if (FWD_EN && d_srcA == e_dstE_i)
      d_valA = e_valE_i;
    else if (FWD_EN && d_srcA == M_dstM_i)
      d_valA = m_valM_i;
    else if (FWD_EN && d_srcA == M_dstE_i)
      d_valA = M_valE_i;
    else if (FWD_EN && d_srcA == W_dstM_i)
      d_valA = W_valM_i;
    else if (FWD_EN && d_srcA == W_dstE_i)
      d_valA = W_valE_i;
    else
      d_valA = rf_a;
  end

  always_comb begin
    if (d_srcB == R_NONE)
      d_valB = '0;
    else if (FWD_EN && d_srcB == e_dstE_i)
      d_valB = e_valE_i;
    else if (FWD_EN && d_srcB == M_dstM_i)
      d_valB = m_valM_i;
    else if (FWD_EN && d_srcB == M_dstE_i)
      d_valB = M_valE_i;
    else if (FWD_EN && d_srcB == W_dstM_i)
      d_valB = W_valM_i;
    else if (FWD_EN && d_srcB == W_dstE_i)
      d_valB = W_valE_i;
    else
      d_valB = rf_b;
  end

  // port M is checked first so it wins a same-register conflict
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n_i)
        rf_q[i] <= (i == 4) ? DATA_W'(RSP_INIT) : '0;
      else if (W_dstM_i != R_NONE && W_dstM_i == 4'(i))
        rf_q[i] <= W_valM_i;
      else if (W_dstE_i != R_NONE && W_dstE_i == 4'(i))
        rf_q[i] <= W_valE_i;
    end
  end

  always_comb begin
    de_d = de_q;
    if (E_bubble_i) begin
      de_d = de_nop();
    end else if (!E_stall_i) begin
      de_d.stat  = D_stat_i;
      de_d.icode = D_icode_i;
      de_d.ifun  = D_ifun_i;
      de_d.valC  = D_valC_i;
      de_d.valA  = d_valA;
      de_d.valB  = d_valB;
      de_d.dstE  = d_dstE;
      de_d.dstM  = d_dstM;
      de_d.srcA  = d_srcA;
      de_d.srcB  = d_srcB;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) de_q <= de_nop();
    else          de_q <= de_d;
  end

  assign d_load_use_o =
    (de_q.icode == I_MRMOVQ || de_q.icode == I_POPQ) &&
    de_q.dstM != R_NONE &&
    (de_q.dstM == d_srcA || de_q.dstM == d_srcB);

  assign E_stat_o  = de_q.stat;
  assign E_icode_o = de_q.icode;
  assign E_ifun_o  = de_q.ifun;
  assign E_valC_o  = de_q.valC;
  assign E_valA_o  = de_q.valA;
  assign E_valB_o  = de_q.valB;
  assign E_dstE_o  = de_q.dstE;
  assign E_dstM_o  = de_q.dstM;
  assign E_srcA_o  = de_q.srcA;
  assign E_srcB_o  = de_q.srcB;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// tb_decode_stage_fwd: directed stimulus with a queued scoreboard
// checked by an independent negedge monitor.
module tb_decode_stage_fwd;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   D_stat;
  logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;
  logic [3:0]   e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [W-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic         E_stall, E_bubble;

  logic         lu1, lu2;
  logic [2:0]   st1, st2;
  logic [3:0]   ic1, ic2, if1, if2;
  logic [W-1:0] vc1, vc2, va1, va2, vb1, vb2;
  logic [3:0]   de1, de2, dm1, dm2, sa1, sa2, sb1, sb2;

  decode_stage_fwd #(.DATA_W(W), .NREG(15)) u1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_stat_i(D_stat), .D_icode_i(D_icode), .D_ifun_i(D_ifun),
    .D_rA_i(D_rA), .D_rB_i(D_rB), .D_valC_i(D_valC), .D_valP_i(D_valP),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .E_stall_i(E_stall), .E_bubble_i(E_bubble),
    .d_load_use_o(lu1), .E_stat_o(st1), .E_icode_o(ic1),
    .E_ifun_o(if1), .E_valC_o(vc1), .E_valA_o(va1), .E_valB_o(vb1),
    .E_dstE_o(de1), .E_dstM_o(dm1), .E_srcA_o(sa1), .E_srcB_o(sb1)
  );

  decode_stage_fwd #(.DATA_W(W), .NREG(8)) u2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_stat_i(D_stat), .D_icode_i(D_icode), .D_ifun_i(D_ifun),
    .D_rA_i(D_rA), .D_rB_i(D_rB), .D_valC_i(D_valC), .D_valP_i(D_valP),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .E_stall_i(E_stall), .E_bubble_i(E_bubble),
    .d_load_use_o(lu2), .E_stat_o(st2), .E_icode_o(ic2),
    .E_ifun_o(if2), .E_valC_o(vc2), .E_valA_o(va2), .E_valB_o(vb2),
    .E_dstE_o(de2), .E_dstM_o(dm2), .E_srcA_o(sa2), .E_srcB_o(sb2)
  );

  typedef enum int {
    F_STAT, F_ICODE, F_VALC, F_VALA, F_VALB, F_DSTE,
    F_DSTM, F_SRCA, F_SRCB, F_LU, F_U2VALA, F_U2DSTE
  } fld_t;

  typedef struct {
    int          due;
    fld_t        sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] field(fld_t s);
    case (s)
      F_STAT:   return 64'(st1);
      F_ICODE:  return 64'(ic1);
      F_VALC:   return vc1;
      F_VALA:   return va1;
      F_VALB:   return vb1;
      F_DSTE:   return 64'(de1);
      F_DSTM:   return 64'(dm1);
      F_SRCA:   return 64'(sa1);
      F_SRCB:   return 64'(sb1);
      F_LU:     return 64'(lu1);
      F_U2VALA: return va2;
      F_U2DSTE: return 64'(de2);
      default:  return 64'hx;
    endcase
  endfunction

  task automatic chk(int due, fld_t s, logic [63:0] v, string nm);
    chk_t c;
    c.due = due; c.sel = s; c.exp = v; c.name = nm;
    q.push_back(c);
  endtask

  // monitor: E_* outputs and d_load_use_o are stable at negedge
  initial begin
    chk_t        c;
    logic [63:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        c   = q.pop_front();
        got = field(c.sel);
        n_tests++;
        if (c.due < cyc) begin
          n_fail++;
          $display("FAIL %s: check missed (due %0d, now %0d)",
                   c.name, c.due, cyc);
        end else if (got !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", c.name, got, c.exp);
        end
      end
    end
  end

  task automatic idle();
    D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0;
    D_rA = 4'hF; D_rB = 4'hF; D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF;
    W_dstM = 4'hF; W_dstE = 4'hF;
    e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;
    E_stall = 1'b0; E_bubble = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();

    // reset state, then %rsp initial value
    rst_n = 1'b1;
    D_icode = 4'h6; D_rA = 4'h4; D_rB = 4'h4;
    chk(t, F_ICODE, 64'h1, "rst_icode");
    chk(t, F_DSTE, 64'hF, "rst_dstE");
    chk(t, F_STAT, 64'h1, "rst_stat");
    chk(t, F_VALA, 64'h0, "rst_valA");
    chk(t + 1, F_VALA, 64'h400, "rsp_valA");
    chk(t + 1, F_VALB, 64'h400, "rsp_valB");
    chk(t + 1, F_DSTE, 64'h4, "opq_dstE");

    // forwarding priority chain on r3
    tick(); idle();
    D_icode = 4'h6; D_rA = 4'h3;
    e_dstE = 4'h3; e_valE = 64'hAA;
    M_dstE = 4'h3; M_valE = 64'hBB;
    W_dstE = 4'h3; W_valE = 64'hCC;
    chk(t + 1, F_VALA, 64'hAA, "fwd_e");
    chk(t + 1, F_VALB, 64'h0, "fwd_srcB_none");
    tick();
    e_dstE = 4'hF;
    chk(t + 1, F_VALA, 64'hBB, "fwd_M_E");
    tick();
    M_dstM = 4'h3; m_valM = 64'hEE;
    chk(t + 1, F_VALA, 64'hEE, "fwd_M_M");
    tick();
    M_dstM = 4'hF; M_dstE = 4'hF;
    W_dstM = 4'h3; W_valM = 64'hDD;
    chk(t + 1, F_VALA, 64'hDD, "fwd_W_M");
    tick();
    W_dstM = 4'hF;
    chk(t + 1, F_VALA, 64'hCC, "fwd_W_E");
    tick();
    W_dstE = 4'hF;
    chk(t + 1, F_VALA, 64'hCC, "rf_r3");

    // both write ports on r5
    tick(); idle();
    W_dstE = 4'h5; W_valE = 64'h11;
    W_dstM = 4'h5; W_valM = 64'h22;
    tick(); idle();
    D_icode = 4'h6; D_rA = 4'h5; D_rB = 4'h5;
    chk(t + 1, F_VALA, 64'h22, "wconf_valA");
    chk(t + 1, F_VALB, 64'h22, "wconf_valB");

    // load-use against MRMOVQ in E
    tick(); idle();
    D_icode = 4'h5; D_rA = 4'h2; D_rB = 4'h7;
    chk(t + 1, F_ICODE, 64'h5, "mr_icode");
    chk(t + 1, F_DSTM, 64'h2, "mr_dstM");
    chk(t + 1, F_SRCB, 64'h7, "mr_srcB");
    tick(); idle();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3; E_stall = 1'b1;
    chk(t, F_LU, 64'h1, "lu_hit");
    tick(); idle();
    D_icode = 4'h6; D_rA = 4'h6; D_rB = 4'h3;
    chk(t, F_LU, 64'h0, "lu_miss");
    chk(t, F_DSTM, 64'h2, "lu_E_held");

    // stall for three cycles, then stall+bubble
    tick(); idle();
    D_icode = 4'h3; D_rB = 4'h9; D_valC = 64'h1234;
    chk(t + 1, F_ICODE, 64'h3, "ir_icode");
    chk(t + 1, F_DSTE, 64'h9, "ir_dstE");
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      E_stall = 1'b1;
      D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2; D_valC = 64'h5555;
      chk(t + 1, F_ICODE, 64'h3, "stall_icode");
      chk(t + 1, F_VALC, 64'h1234, "stall_valC");
      chk(t + 1, F_DSTE, 64'h9, "stall_dstE");
    end
    tick();
    E_bubble = 1'b1;
    chk(t + 1, F_ICODE, 64'h1, "bub_icode");
    chk(t + 1, F_VALC, 64'h0, "bub_valC");
    chk(t + 1, F_DSTE, 64'hF, "bub_dstE");
    chk(t + 1, F_SRCA, 64'hF, "bub_srcA");

    // CALL uses valP for valA and %rsp for srcB/dstE
    tick(); idle();
    D_icode = 4'h8; D_valP = 64'h100; D_stat = 3'd2;
    chk(t + 1, F_VALA, 64'h100, "call_valA");
    chk(t + 1, F_VALB, 64'h400, "call_valB");
    chk(t + 1, F_SRCB, 64'h4, "call_srcB");
    chk(t + 1, F_DSTE, 64'h4, "call_dstE");
    chk(t + 1, F_STAT, 64'h2, "call_stat");

    // r9 exists only in the NREG=15 instance
    tick(); idle();
    W_dstE = 4'h9; W_valE = 64'h77;
    W_dstM = 4'h1; W_valM = 64'h55;
    tick(); idle();
    D_icode = 4'h2; D_rA = 4'h9; D_rB = 4'h1;
    chk(t + 1, F_VALA, 64'h77, "r9_nreg15");
    chk(t + 1, F_U2VALA, 64'h0, "r9_nreg8");
    chk(t + 1, F_U2DSTE, 64'h1, "rr_dstE_nreg8");
    chk(t + 1, F_SRCA, 64'h9, "rr_srcA");

    // reset mid-stream drops E and clears the register file
    tick(); idle();
    rst_n = 1'b0;
    D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
    chk(t + 1, F_ICODE, 64'h1, "rst_mid_icode");
    tick(); idle();
    rst_n = 1'b1;
    D_icode = 4'h2; D_rA = 4'h9; D_rB = 4'h1;
    chk(t + 1, F_VALA, 64'h0, "rst_mid_rf");

    tick(); idle();
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks pending, required 0", q.size());
      n_tests += q.size();
      n_fail  += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
